// File: rtl/e203_subsys_rst_seq.sv
// Reset release sequencer: releases per-domain active-low resets in a fixed order
// with programmable spacing, and re-asserts every domain on watchdog/software requests.
module e203_subsys_rst_seq #(
  parameter int NUM_DOM   = 3,
  parameter int MIN_PULSE = 8,
  parameter int STAGE_DLY = 16,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               test_mode,
  input  logic               wdg_rst_req,
  input  logic               sw_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               rst_busy,
  output logic [1:0]         rst_cause,
  output logic               sw_rst_ack
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDG = 2'b10;

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] DOM_LAST   = IDX_W'(NUM_DOM - 1);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_DOM-1:0] dom_q;
  logic               busy_q;
  logic [1:0]         cause_q;
  logic               ack_q;

  // A watchdog request at any time, or a software request in RUN, re-asserts all domains together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      idx     <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (wdg_rst_req) begin
        state   <= ST_ASSERT;
        cnt     <= '0;
        idx     <= '0;
        dom_q   <= '0;
        busy_q  <= 1'b1;
        cause_q <= CAUSE_WDG;
      end else begin
        case (state)
          ST_ASSERT: begin
            if (cnt == PULSE_LAST) begin
              state <= ST_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (cnt == STAGE_LAST) begin
              dom_q[idx] <= 1'b1;
              cnt        <= '0;
              idx        <= idx + IDX_W'(1);
              if (idx == DOM_LAST) begin
                state  <= ST_RUN;
                busy_q <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            cnt <= '0;
            if (sw_rst_req) begin
              state   <= ST_ASSERT;
              idx     <= '0;
              dom_q   <= '0;
              busy_q  <= 1'b1;
              cause_q <= CAUSE_SW;
              ack_q   <= 1'b1;
            end
          end
          default: begin
            state  <= ST_ASSERT;
            cnt    <= '0;
            idx    <= '0;
            dom_q  <= '0;
            busy_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // DFT bypass drives the domain resets straight from the synchronized reset.
  assign dom_rst_n  = test_mode ? {NUM_DOM{~rst}} : dom_q;
  assign rst_busy   = busy_q;
  assign rst_cause  = cause_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_e203_subsys_rst_seq.sv
// Directed self-checking bench for e203_subsys_rst_seq with default parameters.
module tb_e203_subsys_rst_seq;

  logic       clk;
  logic       rst;
  logic       test_mode;
  logic       wdg_rst_req;
  logic       sw_rst_req;
  logic [2:0] dom_rst_n;
  logic       rst_busy;
  logic [1:0] rst_cause;
  logic       sw_rst_ack;

  int errCount   = 0;
  int checkCount = 0;
  int edgeNum    = 0;

  e203_subsys_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .test_mode  (test_mode),
    .wdg_rst_req(wdg_rst_req),
    .sw_rst_req (sw_rst_req),
    .dom_rst_n  (dom_rst_n),
    .rst_busy   (rst_busy),
    .rst_cause  (rst_cause),
    .sw_rst_ack (sw_rst_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, edgeNum);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic s, input logic t);
    rst         = r;
    wdg_rst_req = w;
    sw_rst_req  = s;
    test_mode   = t;
  endtask

  // One rising edge; outputs are sampled 1ns later, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
    edgeNum++;
  endtask

  task automatic runTo(input int target);
    while (edgeNum < target) tick();
  endtask

  task automatic checkAll(input string tag, input logic [2:0] d, input logic b,
                          input logic [1:0] c, input logic a);
    checkOutput({tag, ".dom"},   32'(dom_rst_n),  32'(d));
    checkOutput({tag, ".busy"},  32'(rst_busy),   32'(b));
    checkOutput({tag, ".cause"}, 32'(rst_cause),  32'(c));
    checkOutput({tag, ".ack"},   32'(sw_rst_ack), 32'(a));
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkAll("por_reset", 3'b000, 1'b1, 2'b00, 1'b0);

    // Power-on release with default spacing: 24/40/56
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edgeNum = 0;
    runTo(23); checkOutput("por_e23_dom", 32'(dom_rst_n), 32'h0);
    runTo(24); checkOutput("por_e24_dom", 32'(dom_rst_n), 32'h1);
    runTo(39); checkOutput("por_e39_dom", 32'(dom_rst_n), 32'h1);
    runTo(40); checkOutput("por_e40_dom", 32'(dom_rst_n), 32'h3);
    runTo(55); checkAll("por_e55", 3'b011, 1'b1, 2'b00, 1'b0);
    runTo(56); checkAll("por_e56", 3'b111, 1'b0, 2'b00, 1'b0);

    // Software reset accepted at edge 60
    runTo(59);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTo(60); checkAll("sw_e60", 3'b000, 1'b1, 2'b01, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTo(61); checkAll("sw_e61", 3'b000, 1'b1, 2'b01, 1'b0);
    runTo(83); checkOutput("sw_e83_dom", 32'(dom_rst_n), 32'h0);
    runTo(84); checkOutput("sw_e84_dom", 32'(dom_rst_n), 32'h1);
    runTo(116); checkAll("sw_e116", 3'b111, 1'b0, 2'b01, 1'b0);

    // Watchdog pulse at edge 30 of a fresh sequence
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edgeNum = 0;
    runTo(29); checkOutput("wdg_e29_dom", 32'(dom_rst_n), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    runTo(30); checkAll("wdg_e30", 3'b000, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTo(53); checkOutput("wdg_e53_dom", 32'(dom_rst_n), 32'h0);
    runTo(54); checkOutput("wdg_e54_dom", 32'(dom_rst_n), 32'h1);
    runTo(85); checkOutput("wdg_e85_dom", 32'(dom_rst_n), 32'h3);
    runTo(86); checkAll("wdg_e86", 3'b111, 1'b0, 2'b10, 1'b0);

    // Simultaneous wdg+sw at edge 87; sw held and acked at 144
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    runTo(87); checkAll("both_e87", 3'b000, 1'b1, 2'b10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    runTo(100); checkAll("both_e100", 3'b000, 1'b1, 2'b10, 1'b0);
    runTo(143); checkAll("both_e143", 3'b111, 1'b0, 2'b10, 1'b0);
    runTo(144); checkAll("both_e144", 3'b000, 1'b1, 2'b01, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runTo(145); checkOutput("both_e145_ack", 32'(sw_rst_ack), 32'h0);

    // rst at edge 35 of the sw-started sequence, wdg also high: rst wins
    runTo(168); checkOutput("mid_e24_dom", 32'(dom_rst_n), 32'h1);
    runTo(178);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    runTo(179); checkAll("mid_e35", 3'b000, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    edgeNum = 0;
    runTo(23); checkOutput("rst2_e23_dom", 32'(dom_rst_n), 32'h0);
    runTo(24); checkOutput("rst2_e24_dom", 32'(dom_rst_n), 32'h1);
    runTo(56); checkAll("rst2_e56", 3'b111, 1'b0, 2'b00, 1'b0);

    // DFT bypass follows ~rst combinationally
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("tm_rst1_dom", 32'(dom_rst_n), 32'h0);
    checkOutput("tm_rst1_busy", 32'(rst_busy), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("tm_rst0_dom", 32'(dom_rst_n), 32'h7);
    checkOutput("tm_rst0_busy", 32'(rst_busy), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("tm_rst1b_dom", 32'(dom_rst_n), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("tm_off_dom", 32'(dom_rst_n), 32'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
